// File: rtl/cpu_params.sv
// rtl/cpu_params.sv - core-wide sizing parameters shared by frontend and backend
package cpu_params;
    localparam int ID_WIDTH = 2;
    localparam int IQ_DEPTH = 8;
    localparam int XLEN     = 32;
endpackage

// File: rtl/uop_types.sv
// rtl/uop_types.sv - fetch bundle and fetch-to-backend field types
package uop_types;
    import cpu_params::*;

    typedef logic [ID_WIDTH-1:0][XLEN-1:0] inst_vec_t;
    typedef logic [ID_WIDTH-1:0][XLEN-1:0] pc_vec_t;
    typedef logic [ID_WIDTH-1:0]           slot_mask_t;

    typedef struct packed {
        inst_vec_t  inst;
        pc_vec_t    pc;
        slot_mask_t mask;
    } fetch_bundle_t;
endpackage

// File: rtl/fifo_backend_itf.sv
// rtl/fifo_backend_itf.sv - valid/ready bundle channel from instruction queue to decode
interface fifo_backend_itf #(
    parameter int ID_WIDTH = cpu_params::ID_WIDTH
);
    logic                       valid;
    logic                       ready;
    logic [ID_WIDTH-1:0][31:0]  inst;
    logic [ID_WIDTH-1:0][31:0]  pc;
    logic [ID_WIDTH-1:0]        mask;

    modport fifo    (output valid, output inst, output pc, output mask, input ready);
    modport backend (input valid, input inst, input pc, input mask, output ready);
endinterface

// File: rtl/iq_ptr.sv
// rtl/iq_ptr.sv - wrap-bit pointer register with increment and synchronous clear
module iq_ptr #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] ptr_d, ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - bundle FIFO between fetch/predecode and backend decode
module inst_queue #(
    parameter int DEPTH    = cpu_params::IQ_DEPTH,
    parameter int ID_WIDTH = cpu_params::ID_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       backend_flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [32*ID_WIDTH-1:0]     in_inst,
    input  logic [32*ID_WIDTH-1:0]     in_pc,
    input  logic [ID_WIDTH-1:0]        in_mask,
    fifo_backend_itf.fifo              to_backend,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0][31:0] inst;
        logic [ID_WIDTH-1:0][31:0] pc;
        logic [ID_WIDTH-1:0]       mask;
    } entry_t;

    entry_t        mem_d [DEPTH];
    entry_t        mem_q [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, push, pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    // No bypass: a full queue refuses even when the backend pops this cycle.
    assign in_ready = !full && !backend_flush;
    assign push     = in_valid && in_ready;
    assign pop      = to_backend.valid && to_backend.ready && !backend_flush;

    iq_ptr #(.PW(AW + 1)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (backend_flush),
        .inc   (push),
        .ptr   (wptr)
    );

    iq_ptr #(.PW(AW + 1)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (backend_flush),
        .inc   (pop),
        .ptr   (rptr)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wptr[AW-1:0]] = '{inst: in_inst, pc: in_pc, mask: in_mask};
        end
    end

    // Entry payload is don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign to_backend.valid = !empty;
    assign to_backend.inst  = mem_q[rptr[AW-1:0]].inst;
    assign to_backend.pc    = mem_q[rptr[AW-1:0]].pc;
    assign to_backend.mask  = mem_q[rptr[AW-1:0]].mask;

    assign occupancy = wptr - rptr;

    a_push_mask_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (in_mask != '0));
    a_mask_contiguous: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |-> ((in_mask & (in_mask + ID_WIDTH'(1))) == '0));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= (AW + 1)'(DEPTH));
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - table vectors plus scoreboard sequences for inst_queue
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int IDW   = 2;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              backend_flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [32*IDW-1:0] in_inst = '0;
    logic [32*IDW-1:0] in_pc = '0;
    logic [IDW-1:0]    in_mask = '0;
    logic [AW:0]       occupancy;

    fifo_backend_itf #(.ID_WIDTH(IDW)) itf ();

    inst_queue #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .backend_flush (backend_flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .in_mask       (in_mask),
        .to_backend    (itf),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  mask;
    } sb_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  m;
        logic        r;
        logic        f;
        logic        exp_rdy;
        logic        exp_v;
        int          exp_occ;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[7];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [63:0] mk_pc(input logic [31:0] pc);
        return {pc + 32'd4, pc};
    endfunction

    function automatic logic [63:0] mk_inst(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0001, pc ^ 32'hA5A5_0000};
    endfunction

    function automatic logic [63:0] slot_bits(input logic [1:0] m);
        return {{32{m[1]}}, {32{m[0]}}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle from posedge+1, checks against the model, then advances the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [1:0] m,
                         input logic r, input logic f, input int tidx);
        logic exp_rdy, exp_v, psh, pp;
        logic [63:0] sel;
        in_valid      = v;
        in_pc         = mk_pc(pc);
        in_inst       = mk_inst(pc);
        in_mask       = m;
        itf.ready     = r;
        backend_flush = f;
        #1;
        exp_rdy = (sb.size() < DEPTH) && !f;
        exp_v   = (sb.size() != 0);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(itf.valid), 64'(exp_v));
        chk("occupancy", 64'(occupancy), 64'(sb.size()));
        if (tidx >= 0) begin
            chk("tbl_in_ready", 64'(in_ready), 64'(tbl[tidx].exp_rdy));
            chk("tbl_valid", 64'(itf.valid), 64'(tbl[tidx].exp_v));
            chk("tbl_occ", 64'(occupancy), 64'(tbl[tidx].exp_occ));
        end
        if (exp_v && r && !f) begin
            sel = slot_bits(sb[0].mask);
            chk("pop_mask", 64'(itf.mask), 64'(sb[0].mask));
            chk("pop_pc", itf.pc & sel, mk_pc(sb[0].pc) & sel);
            chk("pop_inst", itf.inst & sel, mk_inst(sb[0].pc) & sel);
        end
        psh = v && exp_rdy;
        pp  = exp_v && r && !f;
        @(posedge clk);
        if (f) begin
            sb.delete();
        end else begin
            if (pp) void'(sb.pop_front());
            if (psh) sb.push_back('{pc, m});
        end
        #1;
    endtask

    initial begin
        itf.ready = 1'b0;
        tbl[0] = '{1'b1, 32'h1000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[1] = '{1'b1, 32'h1008, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[2] = '{1'b1, 32'h1010, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        tbl[3] = '{1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 3};
        tbl[4] = '{1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[5] = '{1'b0, 32'h0,    2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[6] = '{1'b0, 32'h0,    2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_valid", 64'(itf.valid), 64'd0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].v, tbl[i].pc, tbl[i].m, tbl[i].r, tbl[i].f, i);
        end

        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'h100 + 32'(8 * i), 2'b11, 1'b0, 1'b0, -1);
        end
        chk("full_occ", 64'(occupancy), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h900, 2'b11, 1'b0, 1'b0, -1);
        cycle(1'b1, 32'h908, 2'b11, 1'b1, 1'b0, -1);
        chk("after_pop_in_ready", 64'(in_ready), 64'd1);
        cycle(1'b0, 32'h0, 2'b11, 1'b1, 1'b0, -1);
        cycle(1'b0, 32'h0, 2'b11, 1'b1, 1'b0, -1);
        chk("pre_flush_occ", 64'(occupancy), 64'd5);

        cycle(1'b1, 32'hBEEF0, 2'b11, 1'b1, 1'b1, -1);
        chk("post_flush_valid", 64'(itf.valid), 64'd0);
        chk("post_flush_occ", 64'(occupancy), 64'd0);
        cycle(1'b1, 32'h2000, 2'b11, 1'b0, 1'b0, -1);
        cycle(1'b0, 32'h0, 2'b11, 1'b1, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h5000 + 32'(8 * i), 2'b11, 1'b0, 1'b0, -1);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'h6000 + 32'(8 * i), (i % 3 == 0) ? 2'b01 : 2'b11, 1'b1, 1'b0, -1);
            chk("stream_occ", 64'(occupancy), 64'd3);
        end
        cycle(1'b0, 32'h0, 2'b11, 1'b0, 1'b1, -1);

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h7000 + 32'(8 * i), 2'b11, 1'b0, 1'b0, -1);
        end
        chk("pre_reset_occ", 64'(occupancy), 64'd4);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 64'(itf.valid), 64'd0);
        chk("async_reset_occ", 64'(occupancy), 64'd0);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 32'h4000, 2'b11, 1'b0, 1'b0, -1);
        chk("post_reset_valid", 64'(itf.valid), 64'd1);
        cycle(1'b0, 32'h0, 2'b11, 1'b1, 1'b0, -1);

        cycle(1'b1, 32'h3000, 2'b01, 1'b0, 1'b0, -1);
        cycle(1'b0, 32'h0, 2'b11, 1'b1, 1'b0, -1);
        cycle(1'b0, 32'h0, 2'b11, 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
